// File: rtl/alu_issue.sv
// alu_issue: command-issue and result-capture stage around a 4-bit ALU.
// Commands are queued in a DEPTH-entry FIFO, popped into a stable operand
// register that drives the ALU, and the ALU result/flags are captured into a
// result register offered downstream over a valid/ready handshake.
// Optional feature macro: ALU_ISSUE_STICKY_FLAGS_EN (sticky overflow/carry).
module alu_issue #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [W-1:0]           cmd_a,
  input  logic [W-1:0]           cmd_b,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [2:0]             alu_op,
  input  logic [W-1:0]           alu_s,
  input  logic                   alu_z,
  input  logic                   alu_o,
  input  logic                   alu_c,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_s,
  output logic [2:0]             res_op,
  output logic                   res_z,
  output logic                   res_o,
  output logic                   res_c,
  output logic [$clog2(DEPTH):0] count
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
  ,
  input  logic                   sticky_clr,
  output logic                   sticky_o,
  output logic                   sticky_c
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 + 2 * W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push, pop, fifo_empty;
  logic [EW-1:0]  head;

  // Operand register (drives the ALU)
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;

  // Result register
  logic           capture, release_res;
  logic           res_valid_q, res_valid_d;
  logic [W-1:0]   res_s_q, res_s_d;
  logic [2:0]     res_op_q, res_op_d;
  logic           res_z_q, res_z_d;
  logic           res_o_q, res_o_d;
  logic           res_c_q, res_c_d;
  logic           arith_op;
  logic           flag_o_m, flag_c_m;

  assign cmd_ready  = (count_q < DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid & cmd_ready;
  assign head       = mem_q[rd_ptr_q];

  // Only add/sub report overflow and carry; other ops see them masked to 0.
  assign arith_op = (op_q == 3'b000) || (op_q == 3'b001);
  assign flag_o_m = arith_op & alu_o;
  assign flag_c_m = arith_op & alu_c;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = DRIVE;
      DRIVE:   state_d = HOLD;
      HOLD:    if (res_valid_q && res_ready) state_d = fifo_empty ? IDLE : DRIVE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop, capture and result release strobes
  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE:  pop = !fifo_empty;
      DRIVE: capture = 1'b1;
      HOLD: begin
        release_res = res_valid_q & res_ready;
        pop         = res_valid_q & res_ready & !fifo_empty;
      end
      default: ;
    endcase
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  // Operand register next-state: loads only on a pop edge
  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    if (pop) {op_d, a_d, b_d} = head;
  end

  // Operand register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  // Result register next-state: capture at the end of DRIVE, clear on handshake
  always_comb begin
    res_valid_d = res_valid_q;
    res_s_d     = res_s_q;
    res_op_d    = res_op_q;
    res_z_d     = res_z_q;
    res_o_d     = res_o_q;
    res_c_d     = res_c_q;
    if (release_res) res_valid_d = 1'b0;
    if (capture) begin
      res_valid_d = 1'b1;
      res_s_d     = alu_s;
      res_op_d    = op_q;
      res_z_d     = alu_z;
      res_o_d     = flag_o_m;
      res_c_d     = flag_c_m;
    end
  end

  // Result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_s_q     <= '0;
      res_op_q    <= '0;
      res_z_q     <= 1'b0;
      res_o_q     <= 1'b0;
      res_c_q     <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_s_q     <= res_s_d;
      res_op_q    <= res_op_d;
      res_z_q     <= res_z_d;
      res_o_q     <= res_o_d;
      res_c_q     <= res_c_d;
    end
  end

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
  logic sticky_o_q, sticky_o_d;
  logic sticky_c_q, sticky_c_d;

  // Sticky flags next-state: a setting capture overrides a same-cycle clear
  always_comb begin
    sticky_o_d = sticky_o_q;
    sticky_c_d = sticky_c_q;
    if (sticky_clr) begin
      sticky_o_d = 1'b0;
      sticky_c_d = 1'b0;
    end
    if (capture && flag_o_m) sticky_o_d = 1'b1;
    if (capture && flag_c_m) sticky_c_d = 1'b1;
  end

  // Sticky flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_o_q <= 1'b0;
      sticky_c_q <= 1'b0;
    end else begin
      sticky_o_q <= sticky_o_d;
      sticky_c_q <= sticky_c_d;
    end
  end

  assign sticky_o = sticky_o_q;
  assign sticky_c = sticky_c_q;
`endif

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign res_valid = res_valid_q;
  assign res_s     = res_s_q;
  assign res_op    = res_op_q;
  assign res_z     = res_z_q;
  assign res_o     = res_o_q;
  assign res_c     = res_c_q;
  assign count     = count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: a bit-level ALU stand-in closes the loop, a
// scoreboard queue holds expected results from an integer reference model,
// and a negedge monitor retires them in order.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_s;
  logic       alu_z, alu_o, alu_c;
  logic       res_valid, res_ready;
  logic [3:0] res_s;
  logic [2:0] res_op;
  logic       res_z, res_o, res_c;
  logic [2:0] count;
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
  logic       sticky_clr;
  logic       sticky_o, sticky_c;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cnt = 0;

  logic [9:0] exp_q[$];
  logic [9:0] got[$];
  int         hs_cyc[$];
  logic [9:0] fields;
  logic [9:0] held;
  logic       stall;
  logic [4:0] t;

  assign fields = {res_op, res_s, res_z, res_o, res_c};

  alu_issue #(.DEPTH(4), .W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_s(alu_s), .alu_z(alu_z), .alu_o(alu_o), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_s(res_s), .res_op(res_op),
    .res_z(res_z), .res_o(res_o), .res_c(res_c),
    .count(count)
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_o(sticky_o), .sticky_c(sticky_c)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-in; non-arithmetic ops deliberately raise O and C so masking is exercised
  always_comb begin
    t     = '0;
    alu_o = 1'b1;
    alu_c = 1'b1;
    case (alu_op)
      3'd0: begin
        t     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = t[4];
        alu_o = (alu_a[3] == alu_b[3]) && (t[3] != alu_a[3]);
      end
      3'd1: begin
        t     = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_c = t[4];
        alu_o = (alu_a[3] != alu_b[3]) && (t[3] != alu_a[3]);
      end
      3'd2: t[3:0] = ~alu_a;
      3'd3: t[3:0] = alu_a & alu_b;
      3'd4: t[3:0] = alu_a | alu_b;
      3'd5: t[3:0] = alu_a ^ alu_b;
      3'd6: t[0]   = ($signed(alu_a) < $signed(alu_b));
      default: t[0] = (alu_a == alu_b);
    endcase
    alu_s = t[3:0];
    alu_z = (t[3:0] == 4'd0);
  end

  // Reference: expected {op, s, z, o, c} from integer arithmetic
  function automatic logic [9:0] ref_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r  = 0;
    logic o = 1'b0;
    logic c = 1'b0;
    logic [3:0] s;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 15); o = (sa + sb > 7) || (sa + sb < -8); end
      3'd1: begin r = ua - ub; c = (ua >= ub); o = (sa - sb > 7) || (sa - sb < -8); end
      3'd2: r = 15 - ua;
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      3'd6: r = (sa < sb) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    r = r & 15;
    s = r[3:0];
    return {op, s, (s == 4'd0), o, c};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || res_valid) begin
      n_err++;
      $display("FAIL drain_%s: %0d results still pending after %0d cycles, required 0", nm, exp_q.size(), budget);
    end
  endtask

  // Monitor: record accepts into the scoreboard, retire results on handshake
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(ref_model(cmd_op, cmd_a, cmd_b));
        acc_cnt++;
      end
      if (stall) begin
        check("hold_valid", 32'(res_valid), 32'(1));
        check("hold_fields", 32'(fields), 32'(held));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %0h expected none", fields);
        end else begin
          check("result", 32'(fields), 32'(exp_q.pop_front()));
        end
        got.push_back(fields);
        hs_cyc.push_back(cyc);
        stall = 1'b0;
      end else if (res_valid) begin
        stall = 1'b1;
        held  = fields;
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] bp_op [3];
    logic [3:0] bp_a  [3];
    logic [3:0] bp_b  [3];
    bp_op[0] = 3'b001; bp_a[0] = 4'd3;    bp_b[0] = 4'd5;
    bp_op[1] = 3'b110; bp_a[1] = 4'b1000; bp_b[1] = 4'b0001;
    bp_op[2] = 3'b111; bp_a[2] = 4'd5;    bp_b[2] = 4'd5;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    repeat (3) tick();

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'(0));
    check("rst_res", 32'(fields), 32'(0));
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    check("rst_sticky", 32'({sticky_o, sticky_c}), 32'(0));
`endif
    rst = 1'b0;
    tick();

    // Single add with latency checks: accepted at edge N
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 4'b0111; cmd_b = 4'b0001;
    tick();
    cmd_valid = 1'b0;
    check("add_n_count", 32'(count), 32'(1));
    check("add_n_valid", 32'(res_valid), 32'(0));
    tick();
    check("add_n1_alu", 32'({alu_op, alu_a, alu_b}), 32'({3'b000, 4'b0111, 4'b0001}));
    check("add_n1_valid", 32'(res_valid), 32'(0));
    tick();
    check("add_n2_valid", 32'(res_valid), 32'(1));
    check("add_n2_res", 32'(fields), 32'({3'b000, 4'b1000, 1'b0, 1'b1, 1'b0}));
    res_ready = 1'b1;
    wait_drain("add", 20);
    res_ready = 1'b0;

    // Masking: AND with ALU forcing O=1/C=1
    got.delete();
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 4'b1111; cmd_b = 4'b1111;
    tick();
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain("mask", 20);
    check("mask_count", 32'(got.size()), 32'(1));
    if (got.size() == 1)
      check("mask_res", 32'(got[0]), 32'({3'b011, 4'b1111, 1'b0, 1'b0, 1'b0}));

    // Fill with res_ready low: 6 offered, 5 accepted
    res_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    check("fill_accepted", 32'(acc_cnt), 32'(5));
    check("fill_count", 32'(count), 32'(4));
    check("fill_cmd_ready", 32'(cmd_ready), 32'(0));
    hs_cyc.delete();
    res_ready = 1'b1;
    wait_drain("fill", 40);
    check("fill_results", 32'(hs_cyc.size()), 32'(5));
    for (int i = 1; i < hs_cyc.size(); i++)
      check("fill_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(2));

    // Backpressure and order with res_ready toggling every cycle
    got.delete();
    for (int i = 0; i < 24; i++) begin
      res_ready = (i % 2 == 1);
      if (i < 3) begin
        cmd_valid = 1'b1; cmd_op = bp_op[i]; cmd_a = bp_a[i]; cmd_b = bp_b[i];
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    res_ready = 1'b1;
    wait_drain("bp", 20);
    check("bp_count", 32'(got.size()), 32'(3));
    if (got.size() == 3) begin
      check("bp_sub", 32'(got[0]), 32'({3'b001, 4'b1110, 1'b0, 1'b0, 1'b0}));
      check("bp_slt", 32'(got[1]), 32'({3'b110, 4'b0001, 1'b0, 1'b0, 1'b0}));
      check("bp_eq",  32'(got[2]), 32'({3'b111, 4'b0001, 1'b0, 1'b0, 1'b0}));
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom);
      cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain("random", 40);

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    // Sticky flags
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr0", 32'({sticky_o, sticky_c}), 32'(0));
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 4'b1000; cmd_b = 4'b1000;
    tick();
    cmd_valid = 1'b0;
    wait_drain("sticky_add", 20);
    check("sticky_set", 32'({sticky_o, sticky_c}), 32'(3));
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 4'b0101; cmd_b = 4'b0011;
    tick();
    cmd_valid = 1'b0;
    wait_drain("sticky_and", 20);
    check("sticky_keep", 32'({sticky_o, sticky_c}), 32'(3));
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr1", 32'({sticky_o, sticky_c}), 32'(0));
`endif

    // Reset mid-stream: one in flight, three queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'(3));
    check("pre_rst_valid", 32'(res_valid), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'(0));
    check("mid_rst_count", 32'(count), 32'(0));
    check("mid_rst_alu", 32'({alu_op, alu_a, alu_b}), 32'(0));
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'(1));
    res_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_valid", 32'(res_valid), 32'(0));
    check("post_rst_count", 32'(count), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
